// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_add_ctrl (with helper cell half_adder)             |
// | Purpose  : Bit-serial WIDTH-bit adder. A single full-adder slice,    |
// |            built from two half_adder cells and an OR, is stepped     |
// |            LSB-first over WIDTH cycles under a start/busy/done       |
// |            handshake.                                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

// Single-bit half adder cell reused by the serial datapath.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Counter is at least one bit wide so WIDTH=1 still has a legal vector.
    localparam int             c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_cin;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_ha0_sum;
    logic               w_ha0_carry;
    logic               w_ha1_sum;
    logic               w_ha1_carry;
    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;

    // Full-adder slice: operand LSBs first, then fold in the running carry.
    half_adder u_ha0 (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .sum   (w_ha0_sum),
        .carry (w_ha0_carry)
    );

    half_adder u_ha1 (
        .a     (w_ha0_sum),
        .b     (r_cin),
        .sum   (w_ha1_sum),
        .carry (w_ha1_carry)
    );

    assign w_s    = w_ha1_sum;
    assign w_cout = w_ha0_carry | w_ha1_carry;

    // Result bits enter at the MSB and drift down; after WIDTH shifts the
    // first (LSB) bit computed lands in position 0.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_res_next = {w_s, r_res[WIDTH-1:1]};
        end else begin : g_narrow
            assign w_res_next = w_s;
        end
    endgenerate

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cin   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_cin   <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_cin <= w_cout;
                    if (r_cnt == c_last) begin
                        // Last bit: publish the full result and carry-out.
                        sum     <= w_res_next;
                        carry   <= w_cout;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Single-cycle done; start is not looked at here.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder controller: sequences a single 1-bit full-adder slice (two half_adder instances plus an OR) over WIDTH cycles to add two WIDTH-bit operands.
- Uses a start/busy/done handshake.
- Lets the team build wide adders from the existing half_adder cell, trading area for latency.
- Sits between a requester that supplies operands and the half_adder datapath it owns.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  operand A, captured on the accepted start.
b  input  WIDTH  operand B, captured on the accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  result, a+b mod 2^WIDTH; registered.
carry  output  1  carry-out of the MSB; registered.

Behaviour:
- States: IDLE, RUN, DONE. FSM state, counter, shift registers and outputs are all clocked registers.
- Reset (synchronous, wins over all other inputs):
  - state=IDLE; busy=0, done=0, sum=0, carry=0.
  - Internal carry flop = 0; bit counter = 0.
- IDLE:
  - On a clock edge with start=1: load shift regs ra<=a, rb<=b; internal carry cin<=0; bit counter cnt<=0; state<=RUN.
  - start=0: remain in IDLE; sum/carry hold their last values.
- RUN, one bit per cycle:
  - Datapath: ha0 = half_adder(ra[0], rb[0]); ha1 = half_adder(ha0.sum, cin); bit s = ha1.sum; cout = ha0.carry | ha1.carry.
  - Each edge: ra and rb shift right by 1; s shifts into an internal result register from the MSB side (right shift); cin<=cout; cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge:
    - Last bit is processed.
    - sum<=final result; carry<=cout.
    - state<=DONE.
- DONE:
  - done=1 for exactly this cycle.
  - sum/carry valid from this cycle onward and held until the next accepted start completes.
  - Next edge: state<=IDLE unconditionally.
- busy = (state!=IDLE), decoded from registered state.
- Latency:
  - start sampled at edge E0.
  - RUN occupies cycles after E0..E(WIDTH).
  - done high in the cycle following edge E(WIDTH).
  - Throughput: one op per WIDTH+2 cycles.
  - WIDTH=1: done high the cycle after E1.
- start while busy (RUN or DONE): ignored, not queued. Operand changes while busy: no effect on the result.
- start held continuously: accepted again on the first edge in IDLE, i.e. back-to-back ops with one IDLE cycle between them.
- Reset mid-RUN or in DONE: operation aborted, no done pulse, sum/carry cleared to 0.
- cnt width = clog2(WIDTH), minimum 1 bit; cnt never wraps past WIDTH-1 in RUN.
- No combinational path from start, a or b to any output.

Test Plan:
1. Reset 2 cycles, then idle: busy=0, done=0, sum=0, carry=0 held for 5 cycles; start=1 with rst=1 is not accepted.
2. WIDTH=8, a=3, b=5, start pulse at edge E0: busy rises after E0; done=1 in exactly one cycle, after E8; sum=8, carry=0; values held 10 cycles afterwards.
3. WIDTH=8 carry/wrap cases, each -> done after E8:
   - a=255, b=1 -> sum=0, carry=1.
   - a=170, b=85 -> sum=255, carry=0.
   - a=255, b=255 -> sum=254, carry=1.
4. WIDTH=8, start a=3, b=5; at E3 drive start=1 with a=100, b=100 -> ignored, result is still sum=8. With start then held high, the second op starts one IDLE cycle after done, and its done follows WIDTH+2 cycles after the first done.
5. WIDTH=8, a=255, b=1, assert rst at E4 for one cycle -> no done pulse, busy=0, sum=0, carry=0 after reset; a fresh op a=2, b=2 then gives sum=4.
6. WIDTH=1 instance:
   - a=1, b=1 -> done the cycle after E1, sum=0, carry=1.
   - a=1, b=0 -> sum=1, carry=0.
